// File: rtl/ft_bus_wait_ctrl.sv
// ft_bus_wait_ctrl: region decode, per-region wait states, ready merge, read mux and bus-error record
module ft_bus_wait_ctrl #(
  parameter int NCH = 8,
  parameter int AW = 32,
  parameter int DW = 8,
  parameter logic [NCH*AW-1:0] BASE = '0,
  parameter logic [NCH*AW-1:0] MASK = '0,
  parameter logic [NCH*4-1:0] RWAIT = '0,
  parameter logic [NCH*4-1:0] WWAIT = '0,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] DFLT = '0,
  parameter bit UNMAP_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vda,
  input  logic              vpa,
  input  logic              rw,
  input  logic [AW-1:0]     ad,
  input  logic [NCH*DW-1:0] dati_ch,
  input  logic [NCH-1:0]    rdy_ch,
  output logic [NCH-1:0]    cs_o,
  output logic [DW-1:0]     dato,
  output logic              rdy_o,
  output logic              berr_o,
  output logic [AW-1:0]     berr_adr,
  input  logic              berr_clr
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [TW-1:0] TO = TW'(TIMEOUT);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t r_state;
  logic [3:0] r_wcnt;
  logic [TW-1:0] r_tcnt;
  logic r_berr;
  logic [AW-1:0] r_berr_adr;
  logic w_valid, w_hit, w_rsel, w_to, w_unmap, w_err;
  logic [SW-1:0] w_sel;
  logic [3:0] w_wait;
  // descending scan so the lowest-index hit is the one left standing
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if ((ad & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        w_hit = 1'b1;
        w_sel = SW'(i);
      end
  end
  assign w_valid = vda | vpa;
  assign w_wait  = rw ? RWAIT[w_sel*4 +: 4] : WWAIT[w_sel*4 +: 4];
  assign w_rsel  = rdy_ch[w_sel];
  assign w_to    = (r_state == S_WAIT) && (r_tcnt == TO);
  assign w_unmap = w_valid && !w_hit;
  assign w_err   = (r_state == S_IDLE) ? (w_unmap && UNMAP_ERR) : (w_valid && w_to);
  assign rdy_o   = !w_valid || w_to || ((r_state == S_IDLE) && !w_hit) ||
                   ((r_state == S_IDLE) ? (w_wait == 4'd0 && w_rsel) : (r_wcnt == 4'd0 && w_rsel));
  assign dato    = (w_unmap || w_to || !rw || !w_hit) ? DFLT : dati_ch[w_sel*DW +: DW];
  assign cs_o    = (w_valid && w_hit) ? NCH'(1) << w_sel : '0;
  assign berr_o  = r_berr;
  assign berr_adr = r_berr_adr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wcnt <= '0;
      r_tcnt <= '0;
      r_berr <= 1'b0;
      r_berr_adr <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_valid && w_hit && !rdy_o) begin
          r_state <= S_WAIT;
          r_wcnt <= (w_wait == 4'd0) ? 4'd0 : w_wait - 4'd1;
          r_tcnt <= TW'(1);
        end
      end else if (!w_valid || rdy_o) begin
        r_state <= S_IDLE;
      end else begin
        if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
        r_tcnt <= r_tcnt + 1'b1;
      end
      // a new error beats a coincident clear
      if (w_err) begin
        r_berr <= 1'b1;
        if (!r_berr || berr_clr) r_berr_adr <= ad;
      end else if (berr_clr) begin
        r_berr <= 1'b0;
        r_berr_adr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ft_bus_wait_ctrl.sv
// tb_ft_bus_wait_ctrl: randomized scoreboard bench; two instances differ only in UNMAP_ERR
module tb_ft_bus_wait_ctrl;
  localparam int TO = 32;
  localparam logic [127:0] P_BASE = {32'h00000100, 32'h00100000, 32'h00000000, 32'h00FEB000};
  localparam logic [127:0] P_MASK = {32'hFFFFFF00, 32'hFFFF0000, 32'hFFF00000, 32'hFFFFF000};
  localparam logic [15:0] P_RW = {4'd0, 4'd1, 4'd2, 4'd0};
  localparam logic [15:0] P_WW = {4'd1, 4'd3, 4'd0, 4'd1};
  logic [31:0] m_base [4] = '{32'h00FEB000, 32'h00000000, 32'h00100000, 32'h00000100};
  logic [31:0] m_mask [4] = '{32'hFFFFF000, 32'hFFF00000, 32'hFFFF0000, 32'hFFFFFF00};
  int m_rw [4] = '{0, 2, 1, 0};
  int m_ww [4] = '{1, 0, 3, 1};
  logic clk = 0, rst = 1, vda = 0, vpa = 0, rw = 0, berr_clr = 0;
  logic [31:0] ad = '0, dati_ch = '0;
  logic [3:0] rdy_ch = '1;
  logic [3:0] cs_a, cs_b;
  logic [7:0] dato_a, dato_b;
  logic rdy_a, rdy_b, berr_a, berr_b;
  logic [31:0] adr_a, adr_b;
  always #5 clk = ~clk;
  ft_bus_wait_ctrl #(.NCH(4), .AW(32), .DW(8), .BASE(P_BASE), .MASK(P_MASK), .RWAIT(P_RW), .WWAIT(P_WW),
    .TIMEOUT(TO), .DFLT(8'h00), .UNMAP_ERR(1'b1)) u_a (.clk(clk), .rst(rst), .vda(vda), .vpa(vpa), .rw(rw),
    .ad(ad), .dati_ch(dati_ch), .rdy_ch(rdy_ch), .cs_o(cs_a), .dato(dato_a), .rdy_o(rdy_a), .berr_o(berr_a),
    .berr_adr(adr_a), .berr_clr(berr_clr));
  ft_bus_wait_ctrl #(.NCH(4), .AW(32), .DW(8), .BASE(P_BASE), .MASK(P_MASK), .RWAIT(P_RW), .WWAIT(P_WW),
    .TIMEOUT(TO), .DFLT(8'h00), .UNMAP_ERR(1'b0)) u_b (.clk(clk), .rst(rst), .vda(vda), .vpa(vpa), .rw(rw),
    .ad(ad), .dati_ch(dati_ch), .rdy_ch(rdy_ch), .cs_o(cs_b), .dato(dato_b), .rdy_o(rdy_b), .berr_o(berr_b),
    .berr_adr(adr_b), .berr_clr(berr_clr));
  typedef struct {
    int lat;
    logic [3:0] cs;
    logic [7:0] dat;
    logic ea;
    logic [31:0] aa;
    logic eb;
    logic [31:0] ab;
  } exp_t;
  exp_t q[$];
  exp_t pe;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic pend = 0;
  logic mb_a = 0, mb_b = 0;
  logic [31:0] ma_a = '0, ma_b = '0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (pend) begin
      chk("berr_a", 32'(berr_a), 32'(pe.ea));
      chk("berr_adr_a", adr_a, pe.aa);
      chk("berr_b", 32'(berr_b), 32'(pe.eb));
      chk("berr_adr_b", adr_b, pe.ab);
      pend = 0;
    end
    if (vda | vpa) begin
      cyc++;
      if (rdy_a) begin
        if (q.size() == 0) chk("sb_empty", 32'(q.size()), 1);
        else begin
          pe = q.pop_front();
          chk("latency", cyc, pe.lat);
          chk("cs_a", 32'(cs_a), 32'(pe.cs));
          chk("dato_a", 32'(dato_a), 32'(pe.dat));
          chk("rdy_b", 32'(rdy_b), 1);
          chk("cs_b", 32'(cs_b), 32'(pe.cs));
          chk("dato_b", 32'(dato_b), 32'(pe.dat));
          pend = 1;
        end
        cyc = 0;
      end
    end else begin
      cyc = 0;
      chk("idle_rdy", 32'(rdy_a), 1);
      chk("idle_cs", 32'(cs_a), 0);
    end
  end
  task automatic set_valid();
    int v = $urandom_range(1, 3);
    vda = v[0];
    vpa = v[1];
  endtask
  task automatic go_idle();
    vda = 0; vpa = 0; rdy_ch = '1;
    @(posedge clk); #1;
  endtask
  // reference model: decode, latency = max(w+1, first-ready cycle) capped at the timeout
  task automatic access(input logic [31:0] a, input logic r, input int rr, input logic clr_req);
    exp_t e;
    int reg_i = -1, w = 0;
    logic to = 0, clr, done = 0;
    logic [31:0] d = $urandom;
    for (int i = 0; i < 4; i++) if (reg_i < 0 && (a & m_mask[i]) == m_base[i]) reg_i = i;
    clr = clr_req && reg_i < 0;
    if (reg_i < 0) begin
      e.lat = 1; e.cs = 4'd0; e.dat = 8'h00;
    end else begin
      w = r ? m_rw[reg_i] : m_ww[reg_i];
      e.lat = (w + 1 > rr) ? w + 1 : rr;
      if (e.lat > TO + 1) begin e.lat = TO + 1; to = 1; end
      e.cs = 4'(1 << reg_i);
      e.dat = (r && !to) ? d[reg_i*8 +: 8] : 8'h00;
    end
    if (to || reg_i < 0) begin
      if (!mb_a || clr) ma_a = a;
      mb_a = 1;
    end else if (clr) begin mb_a = 0; ma_a = '0; end
    if (to) begin
      if (!mb_b || clr) ma_b = a;
      mb_b = 1;
    end else if (clr) begin mb_b = 0; ma_b = '0; end
    e.ea = mb_a; e.aa = ma_a; e.eb = mb_b; e.ab = ma_b;
    q.push_back(e);
    ad = a; rw = r; dati_ch = d; berr_clr = clr;
    set_valid();
    for (int k = 1; k <= 100 && !done; k++) begin
      rdy_ch = '1;
      if (reg_i >= 0) rdy_ch[reg_i] = (k >= rr);
      @(negedge clk);
      done = rdy_a;
      @(posedge clk); #1;
      berr_clr = 0;
    end
    chk("complete", 32'(done), 1);
    if ($urandom_range(0, 2) == 0) go_idle();
  endtask
  task automatic do_clr();
    vda = 0; vpa = 0; berr_clr = 1;
    mb_a = 0; ma_a = '0; mb_b = 0; ma_b = '0;
    @(posedge clk); #1;
    berr_clr = 0;
    @(negedge clk);
    chk("clr_berr_a", 32'(berr_a), 0);
    chk("clr_adr_a", adr_a, 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #1;
    @(negedge clk);
    chk("rst_rdy", 32'(rdy_a), 1);
    chk("rst_berr", 32'(berr_a), 0);
    chk("rst_adr", adr_a, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    access(32'h00FEB010, 1, 1, 0);
    access(32'h00000123, 1, 1, 0);
    access(32'h00000123, 0, 1, 0);
    access(32'h00000150, 1, 1, 0);
    access(32'h00000123, 1, 1000, 0);
    go_idle();
    access(32'h00000456, 1, 1000, 0);
    go_idle();
    do_clr();
    access(32'h00FF0000, 1, 1, 0);
    access(32'h00FF1000, 1, 1, 1);
    go_idle();
    // reset mid-WAIT (wcnt=1) with the core dropping valid
    ad = 32'h00000123; rw = 1; vda = 1; rdy_ch = '1;
    @(posedge clk); #1;
    #2 rst = 1; vda = 0; vpa = 0;
    #1;
    chk("rstwait_rdy", 32'(rdy_a), 1);
    chk("rstwait_berr", 32'(berr_a), 0);
    mb_a = 0; ma_a = '0; mb_b = 0; ma_b = '0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    access(32'h00000123, 1, 1, 0);
    for (int n = 0; n < 150; n++) begin
      int ri = $urandom_range(0, 4);
      logic [31:0] a = (ri < 4) ? ((m_base[ri] & m_mask[ri]) | ($urandom & ~m_mask[ri])) : $urandom;
      int rr = ($urandom_range(0, 19) == 0) ? 1000 : $urandom_range(1, 4);
      access(a, 1'($urandom_range(0, 1)), rr, 1'($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 14) == 0) do_clr();
    end
    go_idle();
    go_idle();
    chk("sb_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
